// File: rtl/ctrl_pipeline_if.sv
// Control-pipeline bus: ID-stage inputs, per-stage controls, forwarding and front-end controls.
interface ctrl_pipeline_if;
    logic [9:0]  ctrl_sig;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        branch_taken;

    logic        ex_alu_src;
    logic        ex_reg_dst;
    logic        ex_branch;
    logic [1:0]  ex_alu_op;
    logic [4:0]  ex_wreg;

    logic        mem_read;
    logic        mem_write;
    logic        mem_reg_write;
    logic [4:0]  mem_wreg;

    logic        wb_reg_write;
    logic        wb_mem2reg;
    logic [4:0]  wb_wreg;

    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic [15:0] bubble_cnt;

    // Driver of the ID-stage fields and consumer of the pipeline controls.
    modport master (
        output ctrl_sig, id_rs, id_rt, id_rd, branch_taken,
        input  ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op, ex_wreg,
        input  mem_read, mem_write, mem_reg_write, mem_wreg,
        input  wb_reg_write, wb_mem2reg, wb_wreg,
        input  forward_a, forward_b, pc_write, ifid_write, ifid_flush, bubble_cnt
    );

    // The control pipeline itself.
    modport slave (
        input  ctrl_sig, id_rs, id_rt, id_rd, branch_taken,
        output ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op, ex_wreg,
        output mem_read, mem_write, mem_reg_write, mem_wreg,
        output wb_reg_write, wb_mem2reg, wb_wreg,
        output forward_a, forward_b, pc_write, ifid_write, ifid_flush, bubble_cnt
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// Control pipeline: ID/EX, EX/MEM and MEM/WB control registers with load-use stall,
// branch/jump flush, operand forwarding and a saturating bubble counter.
module ctrl_pipeline (
    input logic           clk,
    input logic           reset,
    ctrl_pipeline_if.slave bus
);

    typedef struct packed {
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem2reg;
        logic [4:0] wreg;
        logic [4:0] rs;
        logic [4:0] rt;
    } idex_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem2reg;
        logic [4:0] wreg;
    } exmem_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem2reg;
        logic [4:0] wreg;
    } memwb_t;

    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    logic load_use;
    logic insert_bubble;
    logic stall;
    logic jump_flush;

    // Hazard detection and front-end stall/flush controls.
    always_comb begin
        load_use = idex_q.mem_read && (idex_q.wreg != 5'd0) &&
                   ((idex_q.wreg == bus.id_rs) || (idex_q.wreg == bus.id_rt));
        // A taken branch makes the ID instruction wrong-path, so its hazard is moot.
        stall         = load_use && !bus.branch_taken;
        insert_bubble = bus.branch_taken || load_use;
        jump_flush    = bus.ctrl_sig[9] && !bus.branch_taken && !load_use;

        // Reset forces the idle front-end values regardless of stale state or inputs.
        bus.pc_write   = reset || !stall;
        bus.ifid_write = reset || !stall;
        bus.ifid_flush = !reset && (bus.branch_taken || jump_flush);
    end

    // Next-state for the three stage registers and the bubble counter.
    always_comb begin
        idex_d           = '0;
        idex_d.branch    = bus.ctrl_sig[8];
        idex_d.alu_src   = bus.ctrl_sig[7];
        idex_d.reg_dst   = bus.ctrl_sig[6];
        idex_d.alu_op    = bus.ctrl_sig[5:4];
        idex_d.mem_read  = bus.ctrl_sig[3];
        idex_d.mem_write = bus.ctrl_sig[2];
        idex_d.reg_write = bus.ctrl_sig[1];
        idex_d.mem2reg   = bus.ctrl_sig[0];
        idex_d.wreg      = bus.ctrl_sig[6] ? bus.id_rd : bus.id_rt;
        idex_d.rs        = bus.id_rs;
        idex_d.rt        = bus.id_rt;
        // A nop carries no destination so it can never look like a producer.
        if (bus.ctrl_sig == 10'd0) begin
            idex_d.wreg = 5'd0;
        end
        if (insert_bubble) begin
            idex_d = '0;
        end

        exmem_d.mem_read  = idex_q.mem_read;
        exmem_d.mem_write = idex_q.mem_write;
        exmem_d.reg_write = idex_q.reg_write;
        exmem_d.mem2reg   = idex_q.mem2reg;
        exmem_d.wreg      = idex_q.wreg;

        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.mem2reg   = exmem_q.mem2reg;
        memwb_d.wreg      = exmem_q.wreg;

        bubble_cnt_d = bubble_cnt_q;
        if (insert_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Stage registers; reset wins over every advance, stall or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            bubble_cnt_q <= 16'd0;
        end else begin
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Forwarding selects from registered state only; EX/MEM beats MEM/WB.
    always_comb begin
        bus.forward_a = 2'b00;
        bus.forward_b = 2'b00;
        if (exmem_q.reg_write && (exmem_q.wreg != 5'd0) && (exmem_q.wreg == idex_q.rs)) begin
            bus.forward_a = 2'b10;
        end else if (memwb_q.reg_write && (memwb_q.wreg != 5'd0) &&
                     (memwb_q.wreg == idex_q.rs)) begin
            bus.forward_a = 2'b01;
        end
        if (exmem_q.reg_write && (exmem_q.wreg != 5'd0) && (exmem_q.wreg == idex_q.rt)) begin
            bus.forward_b = 2'b10;
        end else if (memwb_q.reg_write && (memwb_q.wreg != 5'd0) &&
                     (memwb_q.wreg == idex_q.rt)) begin
            bus.forward_b = 2'b01;
        end
    end

    // Stage control outputs straight from the registers.
    always_comb begin
        bus.ex_alu_src    = idex_q.alu_src;
        bus.ex_reg_dst    = idex_q.reg_dst;
        bus.ex_branch     = idex_q.branch;
        bus.ex_alu_op     = idex_q.alu_op;
        bus.ex_wreg       = idex_q.wreg;
        bus.mem_read      = exmem_q.mem_read;
        bus.mem_write     = exmem_q.mem_write;
        bus.mem_reg_write = exmem_q.reg_write;
        bus.mem_wreg      = exmem_q.wreg;
        bus.wb_reg_write  = memwb_q.reg_write;
        bus.wb_mem2reg    = memwb_q.mem2reg;
        bus.wb_wreg       = memwb_q.wreg;
        bus.bubble_cnt    = bubble_cnt_q;
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: propagation, load-use, forwarding, branch, jump,
// counter saturation and reset during a stall.
module tb_ctrl_pipeline;

    localparam logic [9:0] Lw    = 10'b0010001011;
    localparam logic [9:0] Rtype = 10'b0001100010;
    localparam logic [9:0] Jump  = 10'b1000000000;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    ctrl_pipeline_if bus ();

    ctrl_pipeline dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic br);
        bus.ctrl_sig     = ctrl;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.branch_taken = br;
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ex"}, 16'({bus.ex_alu_src, bus.ex_reg_dst, bus.ex_branch, bus.ex_alu_op,
                                 bus.ex_wreg}), 16'd0);
        check({tag, "_mem"}, 16'({bus.mem_read, bus.mem_write, bus.mem_reg_write,
                                  bus.mem_wreg}), 16'd0);
        check({tag, "_wb"}, 16'({bus.wb_reg_write, bus.wb_mem2reg, bus.wb_wreg}), 16'd0);
        check({tag, "_fwd"}, 16'({bus.forward_a, bus.forward_b}), 16'd0);
        check({tag, "_front"}, 16'({bus.pc_write, bus.ifid_write, bus.ifid_flush}), 16'b110);
        check({tag, "_cnt"}, bus.bubble_cnt, 16'd0);
    endtask

    task automatic drain();
        drive(10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) cyc();
    endtask

    // Producers A then B write a_rd/b_rd; a nop reading src/src then sits in ID/EX.
    task automatic fwd_seq(input string tag, input logic [4:0] a_rd, input logic [4:0] b_rd,
                           input logic [4:0] src, input logic [1:0] exp);
        drive(Rtype, 5'd0, 5'd0, a_rd, 1'b0);
        cyc();
        drive(Rtype, 5'd0, 5'd0, b_rd, 1'b0);
        cyc();
        drive(10'd0, src, src, 5'd0, 1'b0);
        cyc();
        check({tag, "_fa"}, 16'(bus.forward_a), 16'(exp));
        check({tag, "_fb"}, 16'(bus.forward_b), 16'(exp));
        drain();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive(10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) cyc();
        check_idle("reset");
        reset = 1'b0;
        cyc();
        check_idle("post_reset");

        // lw $8: EX at n+1, MEM at n+2, WB at n+3.
        drive(Lw, 5'd0, 5'd8, 5'd3, 1'b0);
        check("lw_front", 16'({bus.pc_write, bus.ifid_write, bus.ifid_flush}), 16'b110);
        cyc();
        drive(10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("lw_ex_alu_src", 16'(bus.ex_alu_src), 16'd1);
        check("lw_ex_wreg", 16'(bus.ex_wreg), 16'd8);
        check("lw_ex_reg_dst", 16'(bus.ex_reg_dst), 16'd0);
        cyc();
        check("lw_mem_read", 16'(bus.mem_read), 16'd1);
        check("lw_mem_wreg", 16'(bus.mem_wreg), 16'd8);
        check("lw_ex_after", 16'(bus.ex_alu_src), 16'd0);
        cyc();
        check("lw_wb", 16'({bus.wb_reg_write, bus.wb_mem2reg, bus.wb_wreg}), 16'h68);
        drain();

        // Load-use: lw $8 in EX, R-type reading $8 in ID.
        drive(Lw, 5'd0, 5'd8, 5'd0, 1'b0);
        cyc();
        drive(Rtype, 5'd8, 5'd5, 5'd10, 1'b0);
        check("lu_stall", 16'({bus.pc_write, bus.ifid_write, bus.ifid_flush}), 16'b000);
        cyc();
        check("lu_bubble", 16'({bus.ex_alu_src, bus.ex_reg_dst, bus.ex_branch, bus.ex_alu_op,
                                bus.ex_wreg}), 16'd0);
        check("lu_cnt", bus.bubble_cnt, 16'd1);
        check("lu_mem_adv", 16'(bus.mem_read), 16'd1);
        check("lu_release", 16'({bus.pc_write, bus.ifid_write}), 16'b11);
        cyc();
        check("lu_rtype_ex", 16'({bus.ex_reg_dst, bus.ex_alu_op, bus.ex_wreg}), 16'b1_10_01010);
        check("lu_fwd_a_wb", 16'(bus.forward_a), 16'b01);
        check("lu_fwd_b", 16'(bus.forward_b), 16'b00);
        drain();

        // Forwarding priority and $0 exclusion.
        fwd_seq("fwd_both", 5'd9, 5'd9, 5'd9, 2'b10);
        fwd_seq("fwd_wb_only", 5'd9, 5'd0, 5'd9, 2'b01);
        fwd_seq("fwd_r0", 5'd0, 5'd0, 5'd0, 2'b00);

        // Branch taken together with a load-use hazard.
        drive(Lw, 5'd0, 5'd8, 5'd0, 1'b0);
        cyc();
        drive(Rtype, 5'd8, 5'd5, 5'd10, 1'b1);
        check("br_hz_front", 16'({bus.pc_write, bus.ifid_write, bus.ifid_flush}), 16'b111);
        cyc();
        check("br_hz_cnt", bus.bubble_cnt, 16'd2);
        check("br_hz_bubble", 16'({bus.ex_reg_dst, bus.ex_alu_op, bus.ex_wreg}), 16'd0);
        // Branch alone.
        drive(Rtype, 5'd1, 5'd2, 5'd3, 1'b1);
        check("br_front", 16'({bus.pc_write, bus.ifid_write, bus.ifid_flush}), 16'b111);
        cyc();
        check("br_cnt", bus.bubble_cnt, 16'd3);

        // Jump: flush but no bubble.
        drive(Jump, 5'd0, 5'd0, 5'd0, 1'b0);
        check("jmp_front", 16'({bus.pc_write, bus.ifid_write, bus.ifid_flush}), 16'b111);
        cyc();
        check("jmp_cnt", bus.bubble_cnt, 16'd3);
        drive(10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("nop_front", 16'({bus.pc_write, bus.ifid_write, bus.ifid_flush}), 16'b110);

        // Saturation: 65532 more bubbles brings 3 to FFFF, more must not wrap.
        drive(10'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        repeat (65532) cyc();
        check("sat_reach", bus.bubble_cnt, 16'hFFFF);
        repeat (4) cyc();
        check("sat_hold", bus.bubble_cnt, 16'hFFFF);
        drive(10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cyc();

        // Reset asserted during a stall.
        drive(Lw, 5'd0, 5'd8, 5'd0, 1'b0);
        cyc();
        drive(Rtype, 5'd8, 5'd5, 5'd10, 1'b0);
        check("rst_pre_stall", 16'({bus.pc_write, bus.ifid_write}), 16'b00);
        reset = 1'b1;
        #1;
        check("rst_front_during", 16'({bus.pc_write, bus.ifid_write, bus.ifid_flush}), 16'b110);
        cyc();
        check_idle("rst_stall");
        reset = 1'b0;
        drive(10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cyc();
        check_idle("rst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
